// File: rtl/sample_stream_src_if.sv
`default_nettype none
// ============================================================================
// Module      : sample_stream_src_if
// Description : Data/valid sample stream between a source and its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sample_stream_src_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data_out;
    logic             dvalid;

    modport master (output data_out, output dvalid);
    modport slave  (input  data_out, input  dvalid);
endinterface
`default_nettype wire

// File: rtl/sample_stream_src.sv
`default_nettype none
// ============================================================================
// Module      : sample_stream_src
// Description : Programmable burst/gap sample generator with running sum/count.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_stream_src #(
    parameter int               WIDTH = 8,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         const_val,
    input  logic [CNT_W-1:0]         burst_len,
    input  logic [CNT_W-1:0]         gap_len,
    input  logic [CNT_W-1:0]         num_bursts,
    input  logic                     hold,
    sample_stream_src_if.master      strm,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH+CNT_W-1:0]   sum_out,
    output logic [CNT_W-1:0]         samp_cnt
);

    localparam logic [WIDTH-1:0] c_seed = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [1:0]             r_mode;
    logic [WIDTH-1:0]       r_const;
    logic [CNT_W-1:0]       r_burst_len;
    logic [CNT_W-1:0]       r_gap_len;
    logic [CNT_W-1:0]       r_burst_rem;
    logic [CNT_W-1:0]       r_bursts_rem;
    logic [CNT_W-1:0]       r_gap_rem;
    logic [WIDTH-1:0]       r_lfsr;
    logic [WIDTH-1:0]       r_ramp;
    logic [WIDTH+CNT_W-1:0] r_sum;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_emit;
    logic                   w_start_ok;
    logic [WIDTH-1:0]       w_sample;

    assign w_emit     = (r_state == S_BURST) && !hold;
    assign w_start_ok = (r_state == S_IDLE) && start;

    always_comb begin
        case (r_mode)
            2'd0:    w_sample = r_lfsr;
            2'd1:    w_sample = r_ramp;
            default: w_sample = r_const;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                // Decide on the live inputs: they are being latched on this same edge.
                if (start) begin
                    if ((burst_len == '0) || (num_bursts == '0)) begin
                        w_state_next = S_FIN;
                    end else begin
                        w_state_next = S_BURST;
                    end
                end
            end
            S_BURST: begin
                if (w_emit && (r_burst_rem == c_one)) begin
                    if (r_bursts_rem == c_one) begin
                        w_state_next = S_FIN;
                    end else if (r_gap_len == '0) begin
                        w_state_next = S_BURST;
                    end else begin
                        w_state_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (!hold && (r_gap_rem == c_one)) begin
                    w_state_next = S_BURST;
                end
            end
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode       <= 2'd0;
            r_const      <= '0;
            r_burst_len  <= '0;
            r_gap_len    <= '0;
            r_burst_rem  <= '0;
            r_bursts_rem <= '0;
            r_gap_rem    <= '0;
            r_lfsr       <= c_seed;
            r_ramp       <= '0;
            r_sum        <= '0;
            r_cnt        <= '0;
        end else if (w_start_ok) begin
            r_mode       <= mode;
            r_const      <= const_val;
            r_burst_len  <= burst_len;
            r_gap_len    <= gap_len;
            r_burst_rem  <= burst_len;
            r_bursts_rem <= num_bursts;
            r_gap_rem    <= gap_len;
            r_lfsr       <= c_seed;
            r_ramp       <= '0;
            r_sum        <= '0;
            r_cnt        <= '0;
        end else begin
            if (w_emit) begin
                r_sum  <= r_sum + {{CNT_W{1'b0}}, w_sample};
                r_cnt  <= r_cnt + c_one;
                r_lfsr <= {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
                r_ramp <= r_ramp + WIDTH'(1);
                if (r_burst_rem == c_one) begin
                    r_burst_rem  <= r_burst_len;
                    r_bursts_rem <= r_bursts_rem - c_one;
                    r_gap_rem    <= r_gap_len;
                end else begin
                    r_burst_rem  <= r_burst_rem - c_one;
                end
            end
            if ((r_state == S_GAP) && !hold) begin
                r_gap_rem <= r_gap_rem - c_one;
            end
        end
    end

    // Outputs are gated so an idle or held cycle always presents zero data.
    assign strm.dvalid   = w_emit;
    assign strm.data_out = w_emit ? w_sample : '0;
    assign busy          = (r_state == S_BURST) || (r_state == S_GAP);
    assign done          = (r_state == S_FIN);
    assign sum_out       = r_sum;
    assign samp_cnt      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sample_stream_src.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_stream_src
// Description : Randomized self-checking bench for sample_stream_src.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_stream_src;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       const_val;
    logic [CNT_W-1:0]       burst_len;
    logic [CNT_W-1:0]       gap_len;
    logic [CNT_W-1:0]       num_bursts;
    logic                   hold;
    logic                   busy;
    logic                   done;
    logic [WIDTH+CNT_W-1:0] sum_out;
    logic [CNT_W-1:0]       samp_cnt;

    sample_stream_src_if #(.WIDTH(WIDTH)) strm ();

    sample_stream_src #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .SEED  (8'h01),
        .TAPS  (8'hB8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .const_val  (const_val),
        .burst_len  (burst_len),
        .gap_len    (gap_len),
        .num_bursts (num_bursts),
        .hold       (hold),
        .strm       (strm),
        .busy       (busy),
        .done       (done),
        .sum_out    (sum_out),
        .samp_cnt   (samp_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    // Reference: expand the run into a timeline of non-held cycles.
    // Entry >= 0 is a sample value, -1 an idle gap cycle, -2 the done cycle.
    task automatic run(input int m, input int cv, input int bl, input int gl, input int nb,
                       input int hold_pct, input int hold_at, input int hold_n,
                       input bit start_noise,
                       output logic [23:0] fsum, output logic [15:0] fcnt,
                       output int done_cyc);
        int          slots[$];
        logic [7:0]  l;
        logic [7:0]  r;
        logic [23:0] exp_sum;
        logic [15:0] exp_cnt;
        int          s;
        int          cyc;
        l        = 8'h01;
        r        = 8'h00;
        done_cyc = -1;
        if (bl != 0 && nb != 0) begin
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < bl; k++) begin
                    case (m)
                        0:       slots.push_back(int'(l));
                        1:       slots.push_back(int'(r));
                        default: slots.push_back(cv);
                    endcase
                    l = lfsr_step(l);
                    r = r + 8'd1;
                end
                if (b != nb - 1)
                    for (int g = 0; g < gl; g++) slots.push_back(-1);
            end
        end
        slots.push_back(-2);

        @(posedge clk); #1;
        mode = 2'(m); const_val = 8'(cv); burst_len = 16'(bl);
        gap_len = 16'(gl); num_bursts = 16'(nb); hold = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the configuration; the run must use the latched copy.
        mode = 2'($urandom); const_val = 8'($urandom); burst_len = 16'($urandom_range(9));
        gap_len = 16'($urandom_range(9)); num_bursts = 16'($urandom_range(9));
        exp_sum = '0;
        exp_cnt = '0;
        cyc     = 0;
        while (slots.size() > 0) begin
            hold  = (($urandom_range(99) < hold_pct) || (cyc >= hold_at && cyc < hold_at + hold_n));
            start = start_noise && ($urandom_range(3) == 0);
            @(negedge clk);
            s = slots[0];
            check("sum", sum_out, exp_sum);
            check("cnt", samp_cnt, exp_cnt);
            if (s == -2) begin
                check("done", done, 1);
                check("dvalid_fin", strm.dvalid, 0);
                check("busy_fin", busy, 0);
                done_cyc = cyc;
                void'(slots.pop_front());
            end else if (hold) begin
                check("dvalid_hold", strm.dvalid, 0);
                check("done_hold", done, 0);
                check("busy_hold", busy, 1);
            end else begin
                check("busy", busy, 1);
                check("done_early", done, 0);
                if (s >= 0) begin
                    check("dvalid", strm.dvalid, 1);
                    check("data", strm.data_out, 64'(s));
                    exp_sum = exp_sum + 24'(s);
                    exp_cnt = exp_cnt + 16'd1;
                end else begin
                    check("dvalid_gap", strm.dvalid, 0);
                end
                void'(slots.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 5000) begin
                check("timeout", 64'(cyc), 0);
                slots.delete();
            end
        end
        hold  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("done_after", done, 0);
        check("busy_after", busy, 0);
        check("dvalid_after", strm.dvalid, 0);
        check("sum_held", sum_out, exp_sum);
        check("cnt_held", samp_cnt, exp_cnt);
        fsum = exp_sum;
        fcnt = exp_cnt;
    endtask

    logic [23:0] s_res;
    logic [15:0] c_res;
    int          d_res;

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; mode = 2'd0; const_val = '0;
        burst_len = '0; gap_len = '0; num_bursts = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dvalid", strm.dvalid, 0);
        check("rst_data", strm.data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum_out, 0);
        check("rst_cnt", samp_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run(0, 0, 5, 0, 1, 0, 0, 0, 1'b0, s_res, c_res, d_res);
        check("lfsr_sum", s_res, 32);
        check("lfsr_cnt", c_res, 5);
        check("lfsr_done_cyc", d_res, 5);

        run(1, 0, 4, 3, 3, 0, 0, 0, 1'b0, s_res, c_res, d_res);
        check("ramp_sum", s_res, 66);
        check("ramp_cnt", c_res, 12);
        check("ramp_done_cyc", d_res, 18);

        run(2, 200, 100, 0, 1, 0, 0, 0, 1'b0, s_res, c_res, d_res);
        check("const_sum", s_res, 20000);
        check("const_cnt", c_res, 100);

        run(1, 0, 6, 0, 1, 0, 2, 3, 1'b0, s_res, c_res, d_res);
        check("hold_cnt", c_res, 6);
        check("hold_sum", s_res, 15);
        check("hold_done_cyc", d_res, 9);

        run(1, 0, 0, 2, 3, 0, 0, 0, 1'b0, s_res, c_res, d_res);
        check("zero_len_cnt", c_res, 0);
        check("zero_len_done_cyc", d_res, 0);
        run(0, 0, 4, 1, 0, 0, 0, 0, 1'b0, s_res, c_res, d_res);
        check("zero_bursts_done_cyc", d_res, 0);

        run(1, 0, 5, 2, 2, 0, 0, 0, 1'b1, s_res, c_res, d_res);
        check("noise_cnt", c_res, 10);

        for (int i = 0; i < 14; i++) begin
            run(int'($urandom_range(3)), int'($urandom_range(255)), int'($urandom_range(6)),
                int'($urandom_range(3)), int'($urandom_range(3)), 25, 0, 0,
                bit'($urandom_range(1)), s_res, c_res, d_res);
        end

        // Reset during the third sample of a 10-sample burst.
        @(posedge clk); #1;
        mode = 2'd0; burst_len = 16'd10; gap_len = 16'd0; num_bursts = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_dvalid", strm.dvalid, 1);
        check("pre_rst_data", strm.data_out, 8'h04);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_dvalid", strm.dvalid, 0);
            check("post_rst_data", strm.data_out, 0);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
            check("post_rst_sum", sum_out, 0);
            check("post_rst_cnt", samp_cnt, 0);
            @(posedge clk); #1;
        end
        run(0, 0, 10, 0, 1, 0, 0, 0, 1'b0, s_res, c_res, d_res);
        check("replay_cnt", c_res, 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_stream_src.md
Name: sample_stream_src

Overview:
- Synthesizable sample-stream transmitter. It drives the data/valid interface that sample_avg receives.
- Emits programmable bursts of samples separated by idle gaps.
- Keeps a running sum and sample count so a bench, or a downstream checker, can compare against the averager output without bench-side arithmetic.
- Sits in front of sample_avg in block-level benches and in the self-test wrapper.

Parameters:
- WIDTH, 8, sample width in bits.
- CNT_W, 16, width of burst_len/gap_len/num_bursts and of samp_cnt.
- SEED, 8'h01, LFSR load value (WIDTH bits); if 0, the value 1 is loaded instead.
- TAPS, 8'hB8, LFSR feedback mask (WIDTH bits).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; accepted only in IDLE.
- mode  in  2  data source: 0 = LFSR, 1 = ramp, 2 = constant, 3 = reserved (behaves as constant).
- const_val  in  WIDTH  sample value for constant mode.
- burst_len  in  CNT_W  samples per burst.
- gap_len  in  CNT_W  idle cycles between bursts.
- num_bursts  in  CNT_W  number of bursts per run.
- hold  in  1  pause request; when high, no sample is emitted and all counters/data sources freeze.
- data_out  out  WIDTH  sample value; meaningful only while dvalid=1.
- dvalid  out  1  sample-valid strobe.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at run end.
- sum_out  out  WIDTH+CNT_W  running sum of emitted samples; wraps modulo 2^(WIDTH+CNT_W).
- samp_cnt  out  CNT_W  number of samples emitted; wraps.

Behaviour:
- Reset: all outputs 0, LFSR = SEED (or 1), ramp = 0, state = IDLE. Reset wins over every other input in the same cycle. Reset mid-run aborts immediately: no done pulse, sum/cnt cleared.
- Start and configuration:
  - On accepted start: latch mode/const_val/burst_len/gap_len/num_bursts; clear sum_out/samp_cnt; reload LFSR to seed; ramp to 0.
  - Inputs changing later do not affect the run. start while busy is ignored.
- FSM states: IDLE, BURST, GAP, FIN.
  - IDLE + start, with latched burst_len=0 or num_bursts=0 -> FIN; no samples emitted.
  - IDLE + start otherwise -> BURST.
  - BURST: each non-hold cycle emits one sample (dvalid=1) and decrements the burst counter.
    - After the last sample of the last burst -> FIN.
    - After the last sample of any other burst -> GAP, or -> BURST directly if gap_len=0.
  - GAP: dvalid=0; counts gap_len cycles, then -> BURST.
  - FIN: done=1 and busy=0 for one cycle, then -> IDLE.
  - hold=1 in BURST or GAP: dvalid=0; no counter, LFSR, ramp or state change. A gap is stretched by hold cycles.
- Latency: the first sample appears on the cycle after start is accepted (registered outputs). done follows the last sample by exactly 1 cycle, plus any hold cycles in between. There is no gap after the final burst.
- busy is high in BURST and GAP.
- Data sources:
  - LFSR: data_out = current LFSR. After each emitted sample, lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
  - Ramp: data_out = ramp. Increments after each emitted sample, wraps at 2^WIDTH, continues across bursts within a run.
  - Constant: data_out = const_val latched at start.
- Accounting: sum_out and samp_cnt update on the same edge that retires a sample, i.e. the cycle after dvalid=1. Both hold their values after done until the next accepted start or reset.

Test Plan:
- LFSR run: mode 0, burst_len 5, num_bursts 1 -> data 01,02,04,08,11 on 5 consecutive dvalid cycles; done on the next cycle; sum_out 32, samp_cnt 5.
- Ramp with gaps: mode 1, burst_len 4, gap_len 3, num_bursts 3 -> dvalid pattern 4 on / 3 off / 4 on / 3 off / 4 on, then done; data 0..11; sum 66; samp_cnt 12.
- Averager feed: mode 2, const 200, burst_len 100, num_bursts 1, output connected to sample_avg -> sum 20000, samp_cnt 100, avg 200.
- Hold: ramp, burst_len 6, hold high for 3 cycles after the 2nd sample -> data 0,1, then 3 dvalid=0 cycles, then 2,3,4,5; done 1 cycle after 5; samp_cnt 6.
- Degenerate/ignored starts: burst_len 0 -> done on the cycle after start with samp_cnt 0 and no dvalid. Separately, start pulsed mid-run -> ignored, run unchanged.
- Reset mid-run: rst high during the 3rd sample of a 10-sample burst -> next cycle all outputs 0 and no done pulse. A new start then replays the sequence from the seed.
